// File: rtl/restoring_divider_pkg.sv
// Shared definitions for multi-cycle arithmetic blocks: FSM state encoding and
// iteration-counter sizing.
package restoring_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Iteration counter must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/restoring_divider_borrow_sub.sv
// Combinational W-bit subtractor a - b with borrow generate/propagate chain.
module borrow_lookahead_sub #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   bw;

  assign bw[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign g[i]    = ~a[i] & b[i];
    assign p[i]    = ~(a[i] ^ b[i]);
    assign bw[i+1] = g[i] | (p[i] & bw[i]);
    assign diff[i] = a[i] ^ b[i] ^ bw[i];
  end

  assign borrow_out = bw[W];

endmodule

// File: rtl/restoring_divider.sv
// Unsigned N-bit sequential restoring divider, one quotient bit per clock,
// behind a start/ready handshake; results held until the next accepted start.
//
// state   | meaning
// ST_IDLE | waiting for start; ready=1
// ST_RUN  | trial subtract/restore iterations, one per clock
// ST_DONE | one-cycle done pulse; results valid
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = cnt_width(N);

  state_t state_q, state_d;

  logic [N:0]    r_q;
  logic [N:0]    r_sh;
  logic [N:0]    r_nxt;
  logic [N:0]    sub_diff;
  logic          sub_borrow;
  logic [N-1:0]  q_q;
  logic [N-1:0]  q_nxt;
  logic [N-1:0]  d_q;
  logic [CW-1:0] cnt_q;
  logic          accept;
  logic          last_iter;

  assign accept    = start && (state_q == ST_IDLE);
  assign last_iter = (state_q == ST_RUN) && (cnt_q == CW'(N - 1));

  // Shift {R,Q} left by one; R never exceeds D so R's msb carries nothing out.
  assign r_sh = (r_q << 1) | {{N{1'b0}}, q_q[N-1]};

  borrow_lookahead_sub #(.W(N + 1)) u_sub (
    .a          (r_sh),
    .b          ({1'b0, d_q}),
    .diff       (sub_diff),
    .borrow_out (sub_borrow)
  );

  assign r_nxt = sub_borrow ? r_sh : sub_diff;
  assign q_nxt = {q_q[N-2:0], ~sub_borrow};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (divisor == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (cnt_q == CW'(N - 1)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = ~ready;
  assign done  = (state_q == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      d_q   <= divisor;
      r_q   <= '0;
      q_q   <= dividend;
      cnt_q <= '0;
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state_q == ST_RUN) begin
      r_q   <= r_nxt;
      q_q   <= q_nxt;
      cnt_q <= cnt_q + CW'(1);
      // Results are taken from the final iteration's next values so they
      // are already valid in the DONE cycle.
      if (last_iter) begin
        quotient    <= q_nxt;
        remainder   <= r_nxt[N-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed-vector and corner-sequence bench for restoring_divider (N=8).
module tb_restoring_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int total = 0;
  int passed = 0;

  restoring_divider #(.N(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Edges counted including the accepting edge; lat is the count at which done is first seen.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r,
                        output logic z, output int lat);
    int w;
    w = 0;
    while (!ready && w < 40) begin
      @(posedge clk); #1; w++;
    end
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    q = quotient;
    r = remainder;
    z = div_by_zero;
    @(posedge clk); #1;
    check("done_single_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [7:0] q, r, eq, er;
    logic       z, ez;
    int         lat, n, seen;
    logic [7:0] a, b;

    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 9};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 9};
    vecs[2] = '{8'd3,   8'd200, 8'd0,   8'd3,  1'b0, 9};
    vecs[3] = '{8'd5,   8'd0,   8'hFF,  8'd5,  1'b1, 1};
    vecs[4] = '{8'd9,   8'd3,   8'd3,   8'd0,  1'b0, 9};
    vecs[5] = '{8'd0,   8'd5,   8'd0,   8'd0,  1'b0, 9};
    vecs[6] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 9};
    vecs[7] = '{8'd200, 8'd13,  8'd15,  8'd5,  1'b0, 9};
    vecs[8] = '{8'd254, 8'd16,  8'd15,  8'd14, 1'b0, 9};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quotient", {24'd0, quotient}, 32'd0);
    check("rst_remainder", {24'd0, remainder}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].dvd, vecs[i].dvs, q, r, z, lat);
      check($sformatf("vec%0d_quotient", i), {24'd0, q}, {24'd0, vecs[i].q});
      check($sformatf("vec%0d_remainder", i), {24'd0, r}, {24'd0, vecs[i].r});
      check($sformatf("vec%0d_dbz", i), {31'd0, z}, {31'd0, vecs[i].z});
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_ready_after", i), {31'd0, ready}, 32'd1);
    end

    // start held high with different operands while busy
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    dividend = 8'd50; divisor = 8'd5;
    n = 1;
    while (!done && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("hold_first_latency", n, 9);
    check("hold_first_quotient", {24'd0, quotient}, 32'd14);
    check("hold_first_remainder", {24'd0, remainder}, 32'd2);
    @(posedge clk); #1;
    check("hold_done_low", {31'd0, done}, 32'd0);
    check("hold_back_idle", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    check("hold_second_accepted", {31'd0, busy}, 32'd1);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("hold_second_latency", n, 9);
    check("hold_second_quotient", {24'd0, quotient}, 32'd10);
    check("hold_second_remainder", {24'd0, remainder}, 32'd0);
    @(posedge clk); #1;
    check("hold_second_done_low", {31'd0, done}, 32'd0);

    // reset during the fourth iteration
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_quotient", {24'd0, quotient}, 32'd0);
    check("abort_remainder", {24'd0, remainder}, 32'd0);
    check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("abort_no_done", seen, 0);
    run_op(8'd200, 8'd13, q, r, z, lat);
    check("post_abort_quotient", {24'd0, q}, 32'd15);
    check("post_abort_remainder", {24'd0, r}, 32'd5);

    // random sweep against a reference model
    for (int k = 0; k < 40; k++) begin
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      ez = (b == 8'd0);
      eq = ez ? 8'hFF : a / b;
      er = ez ? a : a % b;
      run_op(a, b, q, r, z, lat);
      check($sformatf("rnd%0d_%0d/%0d_q", k, a, b), {24'd0, q}, {24'd0, eq});
      check($sformatf("rnd%0d_%0d/%0d_r", k, a, b), {24'd0, r}, {24'd0, er});
      check($sformatf("rnd%0d_%0d/%0d_z", k, a, b), {31'd0, z}, {31'd0, ez});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
